// File: rtl/stream_demux.sv
// stream_demux: 1-to-CHANNELS valid/ready stream demultiplexer.
// Each output channel owns a one-entry register slot, so consumers stall
// independently. The block supports unicast (in_sel) and broadcast
// (in_bcast) delivery. Unicast beats addressed past the last channel are
// accepted and dropped, and a saturating counter records them.
module stream_demux #(
    parameter  int WIDTH    = 2,
    parameter  int CHANNELS = 4,
    parameter  int CNT_W    = 8,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_bcast,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]          bad_sel_cnt
);

    // The select field can encode more codes than there are channels when
    // CHANNELS is not a power of two. The extra codes are the illegal selects.
    localparam int                SEL_CODES = 1 << SEL_W;
    localparam logic [SEL_W:0]    CH_LIMIT  = (SEL_W + 1)'(CHANNELS);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [CHANNELS-1:0]  full_q;
    logic [CHANNELS-1:0]  full_d;
    logic [WIDTH-1:0]     data_q [CHANNELS];
    logic [WIDTH-1:0]     data_d [CHANNELS];
    logic [CHANNELS-1:0]  can_acc;
    logic [CHANNELS-1:0]  load;
    logic [SEL_CODES-1:0] can_acc_ext;
    logic                 sel_legal;
    logic                 xfer;
    logic                 drop;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;

    // A slot can take a beat when it is empty or is being drained this cycle.
    assign can_acc   = ~full_q | out_ready;
    assign sel_legal = ({1'b0, in_sel} < CH_LIMIT);

    // Widen can_acc to cover every select code. This keeps the unicast lookup
    // in range for any value of in_sel.
    always_comb begin
        can_acc_ext                 = '0;
        can_acc_ext[CHANNELS-1:0]   = can_acc;
    end

    // Input readiness. A broadcast needs every slot, and a legal unicast needs
    // only its own slot. An illegal select is always accepted so it can be dropped.
    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = &can_acc;
        end else if (sel_legal) begin
            in_ready = can_acc_ext[in_sel];
        end
    end

    assign xfer = in_valid & in_ready;
    assign drop = xfer & ~in_bcast & ~sel_legal;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_slot
            localparam logic [SEL_W-1:0] IDX = SEL_W'(gi);

            // A load wins over a drain, so the slot stays full when both happen.
            // A drain with no load empties the slot but leaves the data as it was.
            assign load[gi]   = xfer & (in_bcast | (sel_legal & (in_sel == IDX)));
            assign full_d[gi] = load[gi] | (full_q[gi] & ~out_ready[gi]);
            assign data_d[gi] = load[gi] ? in_data : data_q[gi];

            assign out_valid[gi]                = full_q[gi];
            assign out_data[gi*WIDTH +: WIDTH]  = data_q[gi];
        end
    endgenerate

    // The drop counter saturates at its maximum value and never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (drop && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Slot and counter state. Reset empties every slot at once and discards held beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            full_q <= full_d;
            cnt_q  <= cnt_d;
            for (int i = 0; i < CHANNELS; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign bad_sel_cnt = cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed-vector bench for stream_demux.
// The main instance uses 4 channels and is driven from a vector table.
// A second instance uses 3 channels and covers illegal-select drops and saturation.
module tb_stream_demux;

    typedef struct {
        logic       valid;
        logic [1:0] sel;
        logic       bcast;
        logic [1:0] data;
        logic [3:0] ordy;
        logic       exp_rdy;
        logic [3:0] exp_ov;
        logic [7:0] exp_od;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_data;
    logic [1:0] in_sel;
    logic       in_bcast;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data;
    logic [7:0] bad_sel_cnt;

    // 3-channel instance
    logic       c_rst_n;
    logic       c_in_valid;
    logic       c_in_ready;
    logic [1:0] c_in_data;
    logic [1:0] c_in_sel;
    logic       c_in_bcast;
    logic [2:0] c_out_valid;
    logic [2:0] c_out_ready;
    logic [5:0] c_out_data;
    logic [7:0] c_bad_sel_cnt;

    int n_vec  = 0;
    int n_fail = 0;
    int n_cmp  = 0;

    vec_t vecs [18];

    stream_demux #(.WIDTH(2), .CHANNELS(4), .CNT_W(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_bcast   (in_bcast),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .bad_sel_cnt(bad_sel_cnt)
    );

    stream_demux #(.WIDTH(2), .CHANNELS(3), .CNT_W(8)) u_dut3 (
        .clk        (clk),
        .rst_n      (c_rst_n),
        .in_valid   (c_in_valid),
        .in_ready   (c_in_ready),
        .in_data    (c_in_data),
        .in_sel     (c_in_sel),
        .in_bcast   (c_in_bcast),
        .out_valid  (c_out_valid),
        .out_ready  (c_out_ready),
        .out_data   (c_out_data),
        .bad_sel_cnt(c_bad_sel_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one beat on the 4-channel instance. Check in_ready before the edge and state after it.
    task automatic apply4(input vec_t v, input int idx);
        in_valid  = v.valid;
        in_sel    = v.sel;
        in_bcast  = v.bcast;
        in_data   = v.data;
        out_ready = v.ordy;
        #1;
        check($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, {31'd0, v.exp_rdy});
        @(posedge clk);
        #1;
        check($sformatf("v%0d out_valid", idx), {28'd0, out_valid}, {28'd0, v.exp_ov});
        check($sformatf("v%0d out_data", idx), {24'd0, out_data}, {24'd0, v.exp_od});
        check($sformatf("v%0d bad_sel_cnt", idx), {24'd0, bad_sel_cnt}, 32'd0);
        n_vec++;
        $display("vec %0d: valid=%0d sel=%0d bcast=%0d data=%0d ordy=%b -> rdy=%0d ov=%b od=%h",
                 idx, v.valid, v.sel, v.bcast, v.data, v.ordy, v.exp_rdy, out_valid, out_data);
    endtask

    // Drive one beat on the 3-channel instance, then check it.
    task automatic apply3(input string name, input logic valid, input logic [1:0] sel,
                          input logic bcast, input logic [1:0] data, input logic [2:0] ordy,
                          input logic exp_rdy, input logic [2:0] exp_ov,
                          input logic [5:0] exp_od, input logic [7:0] exp_cnt);
        c_in_valid  = valid;
        c_in_sel    = sel;
        c_in_bcast  = bcast;
        c_in_data   = data;
        c_out_ready = ordy;
        #1;
        check({name, " in_ready"}, {31'd0, c_in_ready}, {31'd0, exp_rdy});
        @(posedge clk);
        #1;
        check({name, " out_valid"}, {29'd0, c_out_valid}, {29'd0, exp_ov});
        check({name, " out_data"}, {26'd0, c_out_data}, {26'd0, exp_od});
        check({name, " bad_sel_cnt"}, {24'd0, c_bad_sel_cnt}, {24'd0, exp_cnt});
        n_vec++;
        $display("ch3 %s: valid=%0d sel=%0d bcast=%0d -> ov=%b od=%h cnt=%0d",
                 name, valid, sel, bcast, c_out_valid, c_out_data, c_bad_sel_cnt);
    endtask

    initial begin
        vec_t v;

        // Unicast sweep with every consumer ready
        vecs[0]  = '{1'b1, 2'd0, 1'b0, 2'b00, 4'b1111, 1'b1, 4'b0001, 8'h00};
        vecs[1]  = '{1'b1, 2'd1, 1'b0, 2'b01, 4'b1111, 1'b1, 4'b0010, 8'h04};
        vecs[2]  = '{1'b1, 2'd2, 1'b0, 2'b01, 4'b1111, 1'b1, 4'b0100, 8'h14};
        vecs[3]  = '{1'b1, 2'd3, 1'b0, 2'b11, 4'b1111, 1'b1, 4'b1000, 8'hD4};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 2'b00, 4'b1111, 1'b1, 4'b0000, 8'hD4};
        // Backpressure on channel 2
        vecs[5]  = '{1'b1, 2'd2, 1'b0, 2'b01, 4'b1011, 1'b1, 4'b0100, 8'hD4};
        vecs[6]  = '{1'b1, 2'd2, 1'b0, 2'b10, 4'b1011, 1'b0, 4'b0100, 8'hD4};
        vecs[7]  = '{1'b1, 2'd1, 1'b0, 2'b10, 4'b1011, 1'b1, 4'b0110, 8'hD8};
        vecs[8]  = '{1'b1, 2'd2, 1'b0, 2'b10, 4'b1111, 1'b1, 4'b0100, 8'hE8};
        vecs[9]  = '{1'b0, 2'd0, 1'b0, 2'b00, 4'b1111, 1'b1, 4'b0000, 8'hE8};
        // Broadcast blocked by stalled channel 3, then released
        vecs[10] = '{1'b1, 2'd3, 1'b0, 2'b01, 4'b0111, 1'b1, 4'b1000, 8'h68};
        vecs[11] = '{1'b1, 2'd0, 1'b1, 2'b10, 4'b0111, 1'b0, 4'b1000, 8'h68};
        vecs[12] = '{1'b1, 2'd0, 1'b1, 2'b10, 4'b1111, 1'b1, 4'b1111, 8'hAA};
        // Every slot full and stalled, then a drain and load on the same edge
        vecs[13] = '{1'b0, 2'd0, 1'b0, 2'b00, 4'b0000, 1'b0, 4'b1111, 8'hAA};
        vecs[14] = '{1'b1, 2'd1, 1'b0, 2'b11, 4'b0000, 1'b0, 4'b1111, 8'hAA};
        vecs[15] = '{1'b1, 2'd1, 1'b0, 2'b11, 4'b0010, 1'b1, 4'b1111, 8'hAE};
        vecs[16] = '{1'b0, 2'd0, 1'b0, 2'b00, 4'b1111, 1'b1, 4'b0000, 8'hAE};
        // Fill channel 0 ahead of the mid-stream reset
        vecs[17] = '{1'b1, 2'd0, 1'b0, 2'b01, 4'b0000, 1'b1, 4'b0001, 8'hAD};

        rst_n      = 1'b1;
        c_rst_n    = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_sel     = '0;
        in_bcast   = 1'b0;
        out_ready  = '0;
        c_in_valid = 1'b0;
        c_in_data  = '0;
        c_in_sel   = '0;
        c_in_bcast = 1'b0;
        c_out_ready = '0;

        // Reset takes effect asynchronously, before any clock edge
        #1;
        rst_n   = 1'b0;
        c_rst_n = 1'b0;
        #2;
        check("reset out_valid", {28'd0, out_valid}, 32'd0);
        check("reset out_data", {24'd0, out_data}, 32'd0);
        check("reset bad_sel_cnt", {24'd0, bad_sel_cnt}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset3 out_valid", {29'd0, c_out_valid}, 32'd0);
        check("reset3 bad_sel_cnt", {24'd0, c_bad_sel_cnt}, 32'd0);
        check("reset3 in_ready", {31'd0, c_in_ready}, 32'd1);
        n_vec++;
        $display("reset: ov=%b od=%h cnt=%0d rdy=%0d", out_valid, out_data, bad_sel_cnt, in_ready);
        @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        c_rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            apply4(vecs[i], i);
        end

        // Mid-stream async reset: channel 0 is full, so drop rst_n between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", {28'd0, out_valid}, 32'd0);
        check("async rst out_data", {24'd0, out_data}, 32'd0);
        n_vec++;
        $display("async reset: ov=%b od=%h", out_valid, out_data);
        #2;
        rst_n = 1'b1;
        v = '{1'b1, 2'd0, 1'b0, 2'b11, 4'b1111, 1'b1, 4'b0001, 8'h03};
        apply4(v, 100);

        // 3-channel instance: illegal select drops and saturation
        apply3("c_load0",  1'b1, 2'd0, 1'b0, 2'b11, 3'b000, 1'b1, 3'b001, 6'h03, 8'd0);
        apply3("c_bad1",   1'b1, 2'd3, 1'b0, 2'b01, 3'b000, 1'b1, 3'b001, 6'h03, 8'd1);
        apply3("c_idle",   1'b0, 2'd3, 1'b0, 2'b01, 3'b000, 1'b1, 3'b001, 6'h03, 8'd1);
        apply3("c_bcblk",  1'b1, 2'd0, 1'b1, 2'b10, 3'b000, 1'b0, 3'b001, 6'h03, 8'd1);
        c_in_valid = 1'b1;
        c_in_sel   = 2'd3;
        c_in_bcast = 1'b0;
        for (int i = 0; i < 253; i++) begin
            @(posedge clk);
        end
        #1;
        check("c_cnt254", {24'd0, c_bad_sel_cnt}, 32'd254);
        n_vec++;
        apply3("c_sat255", 1'b1, 2'd3, 1'b0, 2'b01, 3'b000, 1'b1, 3'b001, 6'h03, 8'd255);
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
        end
        #1;
        check("c_cnt300", {24'd0, c_bad_sel_cnt}, 32'd255);
        check("c_ov300", {29'd0, c_out_valid}, 32'd1);
        n_vec++;
        $display("ch3 after 300 bad beats: cnt=%0d ov=%b", c_bad_sel_cnt, c_out_valid);
        c_in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
